// File: rtl/axi_to_mem.sv
`default_nettype none
// ============================================================================
// Module     : axi_to_mem
// Description: AXI4 slave to single-port synchronous memory bridge. Each beat
//              becomes a one-cycle memory access; read data returns 1 cycle
//              after the request. Define AXI_TO_MEM_WRAP_EN to enable WRAP
//              burst arithmetic; otherwise WRAP bursts advance as INCR.
// Revision   : 1.0 - initial release
// ============================================================================
module axi_to_mem #(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // AW channel
  input  logic [AXI_ID_WIDTH-1:0]       aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]     aw_addr,
  input  logic [7:0]                    aw_len,
  input  logic [2:0]                    aw_size,
  input  logic [1:0]                    aw_burst,
  input  logic                          aw_lock,
  input  logic [3:0]                    aw_cache,
  input  logic [2:0]                    aw_prot,
  input  logic [3:0]                    aw_qos,
  input  logic [3:0]                    aw_region,
  input  logic [5:0]                    aw_atop,
  input  logic [AXI_USER_WIDTH-1:0]     aw_user,
  input  logic                          aw_valid,
  output logic                          aw_ready,
  // AR channel
  input  logic [AXI_ID_WIDTH-1:0]       ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]     ar_addr,
  input  logic [7:0]                    ar_len,
  input  logic [2:0]                    ar_size,
  input  logic [1:0]                    ar_burst,
  input  logic                          ar_lock,
  input  logic [3:0]                    ar_cache,
  input  logic [2:0]                    ar_prot,
  input  logic [3:0]                    ar_qos,
  input  logic [3:0]                    ar_region,
  input  logic [AXI_USER_WIDTH-1:0]     ar_user,
  input  logic                          ar_valid,
  output logic                          ar_ready,
  // W channel
  input  logic [AXI_DATA_WIDTH-1:0]     w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
  input  logic                          w_last,
  input  logic [AXI_USER_WIDTH-1:0]     w_user,
  input  logic                          w_valid,
  output logic                          w_ready,
  // B channel
  output logic [AXI_ID_WIDTH-1:0]       b_id,
  output logic [1:0]                    b_resp,
  output logic [AXI_USER_WIDTH-1:0]     b_user,
  output logic                          b_valid,
  input  logic                          b_ready,
  // R channel
  output logic [AXI_ID_WIDTH-1:0]       r_id,
  output logic [AXI_DATA_WIDTH-1:0]     r_data,
  output logic [1:0]                    r_resp,
  output logic                          r_last,
  output logic [AXI_USER_WIDTH-1:0]     r_user,
  output logic                          r_valid,
  input  logic                          r_ready,
  // Memory port
  output logic                          req_o,
  output logic                          we_o,
  output logic [AXI_ADDR_WIDTH-1:0]     addr_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   be_o,
  output logic [AXI_DATA_WIDTH-1:0]     data_o,
  input  logic [AXI_DATA_WIDTH-1:0]     data_i
);

  localparam int unsigned STRB_WIDTH  = AXI_DATA_WIDTH / 8;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READ        = 3'd1,
    WAIT_WVALID = 3'd2,
    WRITE       = 3'd3,
    SEND_B      = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q,    id_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [7:0]                len_q,   len_d;
  logic [2:0]                size_q,  size_d;
  logic [1:0]                burst_q, burst_d;
  logic [7:0]                cnt_q,   cnt_d;

  logic                      unused_inputs;
  assign unused_inputs = ^{aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
                           ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, w_user};

  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [7:0]                len,
    input logic [2:0]                size,
    input logic [1:0]                burst
  );
    logic [AXI_ADDR_WIDTH-1:0] step;
    logic [AXI_ADDR_WIDTH-1:0] aligned;
    logic [AXI_ADDR_WIDTH-1:0] nxt;
`ifdef AXI_TO_MEM_WRAP_EN
    logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
`else
    logic                      unused_len;
`endif
    step    = AXI_ADDR_WIDTH'(1) << size;
    aligned = addr & ~(step - AXI_ADDR_WIDTH'(1));
    nxt     = aligned + step;
`ifdef AXI_TO_MEM_WRAP_EN
    // Wrap window is (len+1)*2^size bytes; keep the window base, wrap the offset.
    wrap_mask = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size) - AXI_ADDR_WIDTH'(1);
    if (burst == BURST_WRAP) begin
      nxt = (aligned & ~wrap_mask) | (nxt & wrap_mask);
    end
`else
    unused_len = ^len;
`endif
    if (burst == BURST_FIXED) begin
      nxt = addr;
    end
    return nxt;
  endfunction

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;

    aw_ready = 1'b0;
    ar_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    r_valid  = 1'b0;
    r_last   = 1'b0;
    req_o    = 1'b0;
    we_o     = 1'b0;
    addr_o   = addr_q;
    be_o     = '0;

    unique case (state_q)
      IDLE: begin
        if (ar_valid) begin
          ar_ready = 1'b1;
          req_o    = 1'b1;
          addr_o   = ar_addr;
          be_o     = {STRB_WIDTH{1'b1}};
          id_d     = ar_id;
          addr_d   = ar_addr;
          len_d    = ar_len;
          size_d   = ar_size;
          burst_d  = ar_burst;
          cnt_d    = 8'd0;
          state_d  = READ;
        end else if (aw_valid) begin
          aw_ready = 1'b1;
          id_d     = aw_id;
          addr_d   = aw_addr;
          len_d    = aw_len;
          size_d   = aw_size;
          burst_d  = aw_burst;
          state_d  = WAIT_WVALID;
          if (w_valid) begin
            w_ready = 1'b1;
            req_o   = 1'b1;
            we_o    = 1'b1;
            addr_o  = aw_addr;
            be_o    = w_strb;
            addr_d  = next_addr(aw_addr, aw_len, aw_size, aw_burst);
            state_d = w_last ? SEND_B : WRITE;
          end
        end
      end

      READ: begin
        r_valid = 1'b1;
        r_last  = (cnt_q == len_q);
        req_o   = 1'b1;
        be_o    = {STRB_WIDTH{1'b1}};
        if (r_ready) begin
          if (r_last) begin
            req_o   = 1'b0;
            be_o    = '0;
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = next_addr(addr_q, len_q, size_q, burst_q);
            addr_o = addr_d;
          end
        end
        // Without r_ready the current address is re-read so data_i stays valid.
      end

      WAIT_WVALID, WRITE: begin
        if (w_valid) begin
          w_ready = 1'b1;
          req_o   = 1'b1;
          we_o    = 1'b1;
          be_o    = w_strb;
          addr_d  = next_addr(addr_q, len_q, size_q, burst_q);
          state_d = w_last ? SEND_B : WRITE;
        end
      end

      SEND_B: begin
        b_valid = 1'b1;
        if (b_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_o = w_data;
  assign r_data = data_i;
  assign r_id   = id_q;
  assign b_id   = id_q;
  assign r_resp = RESP_OKAY;
  assign b_resp = RESP_OKAY;
  assign r_user = '0;
  assign b_user = '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_to_mem.sv
`default_nettype none
// ============================================================================
// Module     : tb_axi_to_mem
// Description: Directed, table-driven bench for axi_to_mem. Honors
//              AXI_TO_MEM_WRAP_EN for the expected WRAP address sequences.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_axi_to_mem;

  localparam int unsigned IDW = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned UW  = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [IDW-1:0] aw_id, ar_id, b_id, r_id;
  logic [AW-1:0]  aw_addr, ar_addr, addr_o;
  logic [7:0]     aw_len, ar_len;
  logic [2:0]     aw_size, ar_size;
  logic [1:0]     aw_burst, ar_burst, b_resp, r_resp;
  logic           aw_valid, aw_ready, ar_valid, ar_ready;
  logic [DW-1:0]  w_data, r_data, data_o;
  logic [DW-1:0]  data_i = '0;
  logic [7:0]     w_strb, be_o;
  logic           w_last, w_valid, w_ready;
  logic           b_valid, b_ready, r_last, r_valid, r_ready;
  logic [UW-1:0]  b_user, r_user;
  logic           req_o, we_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_to_mem #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_lock(1'b0), .aw_cache(4'h0), .aw_prot(3'h0), .aw_qos(4'h0), .aw_region(4'h0),
    .aw_atop(6'h0), .aw_user(1'b0), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_lock(1'b0), .ar_cache(4'h0), .ar_prot(3'h0), .ar_qos(4'h0), .ar_region(4'h0),
    .ar_user(1'b0), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(1'b0),
    .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
    .r_valid(r_valid), .r_ready(r_ready),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o), .data_o(data_o),
    .data_i(data_i)
  );

  // Memory model: read data is a recognisable function of the requested address.
  always @(posedge clk) begin
    if (req_o && !we_o) data_i <= {32'hDEADBEEF, ~addr_o};
  end

  function automatic logic [63:0] rd_word(input logic [31:0] a);
    return {32'hDEADBEEF, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic            wr;
    logic [1:0]      id;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [0:3][31:0] ea;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [1:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int k);
    string tag;
    tag = $sformatf("v%0d", k);
    if (v.wr) begin
      aw_id = v.id; aw_addr = v.addr; aw_len = v.len; aw_size = v.size; aw_burst = v.burst;
      aw_valid = 1'b1;
      for (int i = 0; i <= int'(v.len); i++) begin
        w_valid = 1'b1;
        w_data  = {32'hCAFE0000 | 32'(i), v.addr ^ 32'(i)};
        w_strb  = 8'hFF ^ 8'(i);
        w_last  = (i == int'(v.len));
        #1;
        chk({tag, "_aw_ready"}, aw_ready, (i == 0));
        chk({tag, "_w_ready"}, w_ready, 1);
        chk({tag, "_wreq"}, {req_o, we_o}, 2'b11);
        chk({tag, "_waddr"}, addr_o, v.ea[i]);
        chk({tag, "_be"}, be_o, 8'hFF ^ 8'(i));
        chk({tag, "_wdata"}, data_o, {32'hCAFE0000 | 32'(i), v.addr ^ 32'(i)});
        tick();
        aw_valid = 1'b0;
      end
      w_valid = 1'b0; w_last = 1'b0;
      #1;
      chk({tag, "_b_valid"}, b_valid, 1);
      chk({tag, "_b_id"}, b_id, v.id);
      chk({tag, "_b_resp"}, b_resp, 0);
      tick();
      #1;
      chk({tag, "_b_done"}, b_valid, 0);
    end else begin
      ar_id = v.id; ar_addr = v.addr; ar_len = v.len; ar_size = v.size; ar_burst = v.burst;
      ar_valid = 1'b1;
      #1;
      chk({tag, "_ar_ready"}, ar_ready, 1);
      chk({tag, "_rreq"}, {req_o, we_o}, 2'b10);
      chk({tag, "_raddr0"}, addr_o, v.ea[0]);
      chk({tag, "_rbe"}, be_o, 8'hFF);
      tick();
      ar_valid = 1'b0;
      for (int i = 0; i <= int'(v.len); i++) begin
        #1;
        chk({tag, "_r_valid"}, r_valid, 1);
        chk({tag, "_r_data"}, r_data, rd_word(v.ea[i]));
        chk({tag, "_r_last"}, r_last, (i == int'(v.len)));
        chk({tag, "_r_id"}, r_id, v.id);
        chk({tag, "_r_resp"}, r_resp, 0);
        if (i < int'(v.len)) chk({tag, "_raddr_next"}, {req_o, addr_o}, {1'b1, v.ea[i+1]});
        tick();
      end
      #1;
      chk({tag, "_r_done"}, r_valid, 0);
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(1, 2'd1, 32'h28,  8'd0, 3'd3, 2'd1, 32'h28,  0, 0, 0);
    vecs[1] = mk(0, 2'd2, 32'h0,   8'd0, 3'd3, 2'd1, 32'h0,   0, 0, 0);
    vecs[2] = mk(0, 2'd1, 32'h100, 8'd3, 3'd3, 2'd1, 32'h100, 32'h108, 32'h110, 32'h118);
`ifdef AXI_TO_MEM_WRAP_EN
    vecs[3] = mk(0, 2'd3, 32'h118, 8'd3, 3'd3, 2'd2, 32'h118, 32'h100, 32'h108, 32'h110);
    vecs[8] = mk(1, 2'd1, 32'h88,  8'd1, 3'd3, 2'd2, 32'h88,  32'h80,  0, 0);
`else
    vecs[3] = mk(0, 2'd3, 32'h118, 8'd3, 3'd3, 2'd2, 32'h118, 32'h120, 32'h128, 32'h130);
    vecs[8] = mk(1, 2'd1, 32'h88,  8'd1, 3'd3, 2'd2, 32'h88,  32'h90,  0, 0);
`endif
    vecs[4] = mk(1, 2'd2, 32'h200, 8'd3, 3'd2, 2'd1, 32'h200, 32'h204, 32'h208, 32'h20C);
    vecs[5] = mk(0, 2'd0, 32'h40,  8'd2, 3'd3, 2'd0, 32'h40,  32'h40,  32'h40,  0);
    vecs[6] = mk(0, 2'd1, 32'h33,  8'd1, 3'd1, 2'd1, 32'h33,  32'h34,  0, 0);
    vecs[7] = mk(1, 2'd3, 32'h80,  8'd1, 3'd3, 2'd3, 32'h80,  32'h88,  0, 0);

    rst_n = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
    b_ready = 1'b1; r_ready = 1'b1;

    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_outputs", {aw_ready, ar_ready, w_ready, b_valid, r_valid, req_o, we_o}, 0);
    chk("rst_ids", {r_id, b_id}, 0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

    // Read backpressure: r_ready low 3 cycles on beat 1.
    ar_id = 2'd1; ar_addr = 32'h100; ar_len = 8'd3; ar_size = 3'd3; ar_burst = 2'd1;
    ar_valid = 1'b1;
    tick();
    ar_valid = 1'b0;
    #1;
    chk("bp_beat0", r_data, rd_word(32'h100));
    tick();
    r_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_hold_valid", r_valid, 1);
      chk("bp_hold_data", r_data, rd_word(32'h108));
      chk("bp_hold_req", {req_o, addr_o}, {1'b1, 32'h108});
      chk("bp_hold_last", r_last, 0);
      tick();
    end
    r_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("bp_beat_data", r_data, rd_word(32'h100 + 32'(8 * i)));
      chk("bp_beat_last", r_last, (i == 3));
      tick();
    end
    #1;
    chk("bp_done", r_valid, 0);

    // Priority: AR and AW+W together, read first; then b_ready backpressure.
    ar_id = 2'd0; ar_addr = 32'h300; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'd1;
    ar_valid = 1'b1;
    aw_id = 2'd3; aw_addr = 32'h308; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'd1;
    aw_valid = 1'b1;
    w_valid = 1'b1; w_data = 64'h1122334455667788; w_strb = 8'h0F; w_last = 1'b1;
    #1;
    chk("prio_ar", {ar_ready, aw_ready, w_ready, we_o}, 4'b1000);
    chk("prio_addr", addr_o, 32'h300);
    tick();
    ar_valid = 1'b0;
    #1;
    chk("prio_rvalid", {r_valid, r_last, aw_ready, w_ready}, 4'b1100);
    chk("prio_rdata", r_data, rd_word(32'h300));
    tick();
    b_ready = 1'b0;
    #1;
    chk("prio_aw", {aw_ready, w_ready, req_o, we_o}, 4'b1111);
    chk("prio_waddr", {addr_o, be_o}, {32'h308, 8'h0F});
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    ar_addr = 32'h400; ar_id = 2'd2; ar_valid = 1'b1;
    aw_valid = 1'b1; aw_addr = 32'h500;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bbp_hold", {b_valid, b_id}, {1'b1, 2'd3});
      chk("bbp_block", {ar_ready, aw_ready, req_o}, 3'b000);
      tick();
    end
    b_ready = 1'b1;
    aw_valid = 1'b0;
    #1;
    chk("bbp_release", {b_valid, ar_ready}, 2'b10);
    tick();
    #1;
    chk("bbp_ar_next", {b_valid, ar_ready, addr_o}, {2'b01, 32'h400});
    tick();
    ar_valid = 1'b0;
    #1;
    chk("bbp_rdata", {r_valid, r_id, r_data}, {1'b1, 2'd2, rd_word(32'h400)});
    tick();

    // Late W: AW one cycle before W.
    aw_id = 2'd1; aw_addr = 32'h500; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'd1;
    aw_valid = 1'b1;
    #1;
    chk("late_aw", {aw_ready, w_ready, req_o}, 3'b100);
    tick();
    aw_valid = 1'b0;
    #1;
    chk("late_wait", {w_ready, req_o, b_valid}, 3'b000);
    tick();
    w_valid = 1'b1; w_data = 64'hA5A5A5A5_5A5A5A5A; w_strb = 8'hF0; w_last = 1'b1;
    #1;
    chk("late_w", {w_ready, req_o, we_o}, 3'b111);
    chk("late_waddr", {addr_o, be_o, data_o}, {32'h500, 8'hF0, 64'hA5A5A5A5_5A5A5A5A});
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    #1;
    chk("late_b", {b_valid, b_id}, {1'b1, 2'd1});
    tick();
    #1;
    chk("late_b_once", b_valid, 0);
    tick();

    // Reset mid-burst aborts without a response.
    ar_id = 2'd1; ar_addr = 32'h600; ar_len = 8'd3; ar_size = 3'd3; ar_burst = 2'd1;
    ar_valid = 1'b1;
    tick();
    ar_valid = 1'b0;
    #1;
    chk("rst_mid_pre", r_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_abort", {r_valid, req_o, b_valid}, 3'b000);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_idle", {r_valid, req_o, r_id}, 0);
    tick();
    ar_id = 2'd2; ar_addr = 32'h8; ar_len = 8'd0; ar_valid = 1'b1;
    tick();
    ar_valid = 1'b0;
    #1;
    chk("rst_recover", {r_valid, r_last, r_id, r_data}, {2'b11, 2'd2, rd_word(32'h8)});
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
